// File: rtl/maria_dma_sched.sv
// Maria display-list DMA scheduler: turns line/frame strobes into halted-CPU DMA windows.
// Optional statistics (dma_cycles, lost_lines) are built when MARIA_DMA_STATS_EN is defined.
module maria_dma_sched #(
    parameter int unsigned STARTUP_CYC  = 16,
    parameter int unsigned SHUTDOWN_CYC = 24
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       mclk0,
    input  logic       dma_en,
    input  logic       vblank,
    input  logic       vbe,
    input  logic       lrc,
    input  logic       prst,
    input  logic       cpu_halted,
    input  logic       dma_done,
    output logic       halt_n,
    output logic       bus_grant,
    output logic       dma_start,
    output logic       dma_kind,
    output logic       dma_abort,
    output logic       busy,
    output logic [8:0] dma_cycles,
    output logic [7:0] lost_lines
);
    localparam logic [8:0] START_LD = 9'(STARTUP_CYC);
    localparam logic [8:0] SHUT_LD  = 9'(SHUTDOWN_CYC);

    typedef enum logic [2:0] {IDLE, HALT_WAIT, STARTUP, RUN, SHUTDOWN} state_e;

    state_e     state_q, state_d;
    logic [8:0] cnt_q, cnt_d;
    logic       frame_pend_q, frame_pend_d;
    logic       line_pend_q, line_pend_d;
    logic       kind_q, kind_d;
    logic       start_q, start_d;
    logic       abort_q, abort_d;
    logic       take_frame, take_line;
    logic       vbe_ok, lrc_ok;

    assign vbe_ok = vbe & dma_en;
    assign lrc_ok = lrc & ~vblank & dma_en;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        kind_d     = kind_q;
        start_d    = 1'b0;
        abort_d    = 1'b0;
        take_frame = 1'b0;
        take_line  = 1'b0;
        if (mclk0) begin
            unique case (state_q)
                IDLE: begin
                    if (frame_pend_q) begin
                        take_frame = 1'b1;
                        kind_d     = 1'b1;
                        state_d    = HALT_WAIT;
                    end else if (line_pend_q) begin
                        take_line = 1'b1;
                        kind_d    = 1'b0;
                        state_d   = HALT_WAIT;
                    end
                end
                HALT_WAIT: begin
                    if (cpu_halted) begin
                        cnt_d   = START_LD;
                        state_d = STARTUP;
                    end
                end
                // A load of 0 or 1 both leave after a single tick.
                STARTUP: begin
                    if (cnt_q <= 9'd1) begin
                        cnt_d   = '0;
                        state_d = RUN;
                        start_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 9'd1;
                    end
                end
                RUN: begin
                    if (dma_done) begin
                        cnt_d   = SHUT_LD;
                        state_d = SHUTDOWN;
                    end else if (prst && !kind_q) begin
                        abort_d = 1'b1;
                        cnt_d   = SHUT_LD;
                        state_d = SHUTDOWN;
                    end
                end
                SHUTDOWN: begin
                    if (cnt_q <= 9'd1) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 9'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        frame_pend_d = frame_pend_q;
        line_pend_d  = line_pend_q;
        if (mclk0) begin
            if (!dma_en) begin
                frame_pend_d = 1'b0;
                line_pend_d  = 1'b0;
            end else begin
                frame_pend_d = (frame_pend_q & ~take_frame) | vbe_ok;
                line_pend_d  = (line_pend_q & ~take_line) | lrc_ok;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            frame_pend_q <= 1'b0;
            line_pend_q  <= 1'b0;
            kind_q       <= 1'b0;
            start_q      <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            frame_pend_q <= frame_pend_d;
            line_pend_q  <= line_pend_d;
            kind_q       <= kind_d;
            start_q      <= start_d;
            abort_q      <= abort_d;
        end
    end

    assign halt_n    = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign bus_grant = (state_q == RUN);
    assign dma_start = start_q;
    assign dma_abort = abort_q;
    assign dma_kind  = kind_q;

`ifdef MARIA_DMA_STATS_EN
    logic [8:0] cyc_q, cyc_d, cyc_inc, last_q, last_d;
    logic [7:0] lost_q, lost_d;
    logic       line_drop;

    // A strobe landing on a still-pending line request is lost, unless IDLE consumes it this tick.
    assign line_drop = mclk0 & lrc_ok & line_pend_q & ~take_line;
    assign cyc_inc   = (cyc_q == 9'h1FF) ? cyc_q : cyc_q + 9'd1;

    always_comb begin
        cyc_d  = cyc_q;
        last_d = last_q;
        lost_d = lost_q;
        if (mclk0 && state_q != IDLE) begin
            if (state_d == IDLE) begin
                last_d = cyc_inc;
                cyc_d  = '0;
            end else begin
                cyc_d = cyc_inc;
            end
        end
        if (line_drop && lost_q != 8'hFF)
            lost_d = lost_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_q  <= '0;
            last_q <= '0;
            lost_q <= '0;
        end else begin
            cyc_q  <= cyc_d;
            last_q <= last_d;
            lost_q <= lost_d;
        end
    end

    assign dma_cycles = last_q;
    assign lost_lines = lost_q;
`else
    assign dma_cycles = '0;
    assign lost_lines = '0;
`endif

endmodule

// File: tb/tb_maria_dma_sched.sv
// Bench for maria_dma_sched: vector table, directed corner sequences and a randomized
// run checked every tick against a timestamp-based job model.
module tb_maria_dma_sched;
    localparam int S = 16;
    localparam int D = 24;
`ifdef MARIA_DMA_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0, reset_n = 1'b0, mclk0 = 1'b0;
    logic dma_en = 1'b0, vblank = 1'b0, vbe = 1'b0, lrc = 1'b0, prst = 1'b0;
    logic cpu_halted = 1'b0, dma_done = 1'b0;
    logic halt_n, bus_grant, dma_start, dma_kind, dma_abort, busy;
    logic [8:0] dma_cycles;
    logic [7:0] lost_lines;

    maria_dma_sched dut (
        .clk(clk), .reset_n(reset_n), .mclk0(mclk0), .dma_en(dma_en), .vblank(vblank),
        .vbe(vbe), .lrc(lrc), .prst(prst), .cpu_halted(cpu_halted), .dma_done(dma_done),
        .halt_n(halt_n), .bus_grant(bus_grant), .dma_start(dma_start), .dma_kind(dma_kind),
        .dma_abort(dma_abort), .busy(busy), .dma_cycles(dma_cycles), .lost_lines(lost_lines)
    );

    always #5 clk = ~clk;

    int nvec = 0, nfail = 0, n = 0;
    logic s_start, s_abort;

    // Job model: a job is a set of tick timestamps (halt fall, grant, end, release).
    bit m_act, m_fp, m_lp, m_kind, m_grant, e_start, e_abort;
    int m_tfall, m_tgrant, m_tend, m_trise, m_cycles, m_lost;

    typedef struct {
        logic vbe, lrc, vblank, en, halted;
        logic e_halt_n, e_busy, e_grant;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s @tick %0d: got %h, expected %h", name, n, act, exp);
        end
    endtask

    function automatic logic [22:0] act_vec();
        return {halt_n, bus_grant, busy, dma_start, dma_abort, dma_kind, dma_cycles, lost_lines};
    endfunction

    function automatic logic [22:0] exp_vec();
        return {!m_act, m_grant, m_act, e_start, e_abort, m_kind, 9'(m_cycles), 8'(m_lost)};
    endfunction

    task automatic model_reset();
        m_act = 0; m_fp = 0; m_lp = 0; m_kind = 0; m_grant = 0;
        e_start = 0; e_abort = 0; m_cycles = 0; m_lost = 0;
        m_tfall = -1; m_tgrant = -1; m_tend = -1; m_trise = -1;
    endtask

    task automatic model_tick();
        bit tf = 0, tl = 0, lrc_ok;
        e_start = 0;
        e_abort = 0;
        if (!m_act) begin
            if (m_fp || m_lp) begin
                m_act = 1; m_kind = m_fp; tf = m_fp; tl = !m_fp;
                m_tfall = n; m_tgrant = -1; m_tend = -1; m_trise = -1;
            end
        end else if (m_tgrant < 0) begin
            if (cpu_halted) m_tgrant = n + ((S == 0) ? 1 : S);
        end else if (n < m_tgrant) begin
        end else if (n == m_tgrant) begin
            e_start = 1; m_grant = 1;
        end else if (m_tend < 0) begin
            if (dma_done || (prst && !m_kind)) begin
                e_abort = !dma_done; m_grant = 0;
                m_tend = n; m_trise = n + ((D == 0) ? 1 : D);
            end
        end else if (n == m_trise) begin
            m_act = 0;
            if (STATS) m_cycles = (n - m_tfall > 511) ? 511 : n - m_tfall;
        end
        lrc_ok = lrc && !vblank;
        if (!dma_en) begin
            m_fp = 0; m_lp = 0;
        end else begin
            if (STATS && lrc_ok && m_lp && !tl && m_lost < 255) m_lost++;
            m_fp = (m_fp && !tf) || vbe;
            m_lp = (m_lp && !tl) || lrc_ok;
        end
    endtask

    // One mclk0 tick, then 1-2 non-tick clocks with junk inputs that must have no effect.
    task automatic tick();
        logic [6:0] sv;
        int gap;
        mclk0 = 1'b1;
        @(posedge clk); #1;
        model_tick();
        s_start = dma_start;
        s_abort = dma_abort;
        chk("tick", act_vec(), exp_vec());
        n++;
        mclk0 = 1'b0;
        gap = $urandom_range(1, 2);
        sv = {dma_en, vblank, vbe, lrc, prst, cpu_halted, dma_done};
        for (int g = 0; g < gap; g++) begin
            {dma_en, vblank, vbe, lrc, prst, cpu_halted, dma_done} = 7'($urandom);
            @(posedge clk); #1;
        end
        {dma_en, vblank, vbe, lrc, prst, cpu_halted, dma_done} = sv;
        e_start = 0;
        e_abort = 0;
        chk("hold", act_vec(), exp_vec());
    endtask

    task automatic run_until(input int sel, input logic val, input int maxt, output int cnt);
        cnt = 0;
        while (((sel == 0) ? halt_n : bus_grant) !== val && cnt < maxt) begin
            tick();
            cnt++;
        end
        if (cnt >= maxt) chk("timeout", (sel == 0) ? halt_n : bus_grant, val);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("reset", act_vec(), {1'b1, 22'd0});
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c, falls;
        logic prev;
        tbl[0] = '{0, 0, 0, 1, 0, 1, 0, 0};
        tbl[1] = '{0, 1, 1, 1, 0, 1, 0, 0};
        tbl[2] = '{0, 0, 0, 1, 0, 1, 0, 0};
        tbl[3] = '{0, 1, 0, 0, 0, 1, 0, 0};
        tbl[4] = '{0, 0, 0, 1, 0, 1, 0, 0};
        tbl[5] = '{0, 1, 0, 1, 0, 1, 0, 0};
        tbl[6] = '{0, 0, 0, 1, 0, 0, 1, 0};
        tbl[7] = '{0, 0, 0, 1, 0, 0, 1, 0};
        tbl[8] = '{0, 0, 0, 1, 1, 0, 1, 0};

        model_reset();
        #1;
        chk("reset", act_vec(), {1'b1, 22'd0});
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Filters (vblank, dma_en), latch-to-halt latency, waiting on cpu_halted.
        for (int i = 0; i < 9; i++) begin
            {vbe, lrc, vblank, dma_en, cpu_halted} =
                {tbl[i].vbe, tbl[i].lrc, tbl[i].vblank, tbl[i].en, tbl[i].halted};
            tick();
            chk("tbl", {halt_n, busy, bus_grant}, {tbl[i].e_halt_n, tbl[i].e_busy, tbl[i].e_grant});
        end
        lrc = 0;
        run_until(1, 1'b1, 40, c);
        chk("tbl_kind", {s_start, dma_kind}, 2'b10);
        dma_done = 1; tick(); dma_done = 0;
        run_until(0, 1'b1, 40, c);

        // Frame job: grant 17 ticks after halt, done 40 ticks after start.
        vbe = 1; tick(); vbe = 0;
        run_until(0, 1'b0, 10, c);
        run_until(1, 1'b1, 40, c);
        chk("grant_lat", c, 1 + S);
        chk("frame_start", {s_start, dma_kind}, 2'b11);
        repeat (39) tick();
        dma_done = 1; tick(); dma_done = 0;
        chk("grant_fall", bus_grant, 0);
        run_until(0, 1'b1, 40, c);
        chk("shutdown", c, D);
        chk("dma_cycles", dma_cycles, STATS ? 81 : 0);

        // Frame and line on one tick: frame first, line one tick after halt rises.
        vbe = 1; lrc = 1; tick(); vbe = 0; lrc = 0;
        run_until(1, 1'b1, 40, c);
        chk("both_kind", dma_kind, 1);
        dma_done = 1; tick(); dma_done = 0;
        run_until(0, 1'b1, 40, c);
        tick();
        chk("line_follow", halt_n, 0);
        chk("lost0", lost_lines, 0);
        run_until(1, 1'b1, 40, c);
        chk("line_kind", {s_start, dma_kind}, 2'b10);

        // prst aborts a line job.
        prst = 1; tick(); prst = 0;
        chk("abort", {s_abort, bus_grant}, 2'b10);
        run_until(0, 1'b1, 40, c);
        chk("abort_shut", c, D);

        // prst together with dma_done: no abort.
        lrc = 1; tick(); lrc = 0;
        run_until(1, 1'b1, 40, c);
        prst = 1; dma_done = 1; tick(); prst = 0; dma_done = 0;
        chk("no_abort", {s_abort, bus_grant}, 2'b00);
        run_until(0, 1'b1, 40, c);

        // Three lrc strobes around one long line job: one dropped, one more job.
        lrc = 1; tick(); lrc = 0;
        run_until(0, 1'b0, 10, c);
        repeat (3) tick();
        lrc = 1; tick(); lrc = 0;
        repeat (5) tick();
        lrc = 1; tick(); lrc = 0;
        chk("lost1", lost_lines, STATS ? 1 : 0);
        run_until(1, 1'b1, 40, c);
        repeat (10) tick();
        dma_done = 1; tick(); dma_done = 0;
        run_until(0, 1'b1, 40, c);
        falls = 0;
        prev = halt_n;
        repeat (60) begin
            tick();
            if (prev && !halt_n) falls++;
            prev = halt_n;
        end
        chk("line_jobs", falls, 1);
        dma_done = 1; tick(); dma_done = 0;
        run_until(0, 1'b1, 40, c);

        // Asynchronous reset while the bus is granted.
        vbe = 1; tick(); vbe = 0;
        run_until(1, 1'b1, 40, c);
        do_reset();
        repeat (5) tick();
        chk("post_reset_idle", {busy, halt_n}, 2'b01);

        // Randomized traffic against the model.
        vblank = 0; dma_en = 1;
        for (int i = 0; i < 1500; i++) begin
            vbe        = ($urandom_range(0, 59) == 0);
            lrc        = ($urandom_range(0, 19) == 0);
            prst       = ($urandom_range(0, 14) == 0);
            dma_done   = ($urandom_range(0, 29) == 0);
            cpu_halted = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 49) == 0) vblank = ~vblank;
            dma_en     = ($urandom_range(0, 39) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
